// File: rtl/mips_exc_pkg.sv
// Shared MIPS exception definitions: ExcCodes, the BEV=1 general exception vector,
// and the commit controller state encoding.
package mips_exc_pkg;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0a;
   localparam logic [4:0] EXC_OV   = 5'h0c;

   localparam logic [31:0] EXC_VECTOR_BEV = 32'hbfc00380;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_REDIRECT = 1'b1
   } exc_state_e;

endpackage

// File: rtl/exc_int_sampler.sv
// Registers the interrupt-pending condition, blanking it for one cycle after an
// MTC0 commit so Status/Cause writes take effect before the next sample.
module exc_int_sampler
   import mips_exc_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] int_req,
   input  logic       cp0_status_ie,
   input  logic       cp0_status_exl,
   input  logic       mtc0_commit,
   output logic       int_pend
);

   logic mask_hold;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mask_hold <= 1'b0;
         int_pend  <= 1'b0;
      end else begin
         mask_hold <= mtc0_commit;
         int_pend  <= (|int_req) & cp0_status_ie & ~cp0_status_exl & ~mask_hold;
      end
   end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Writeback exception/interrupt/ERET commit controller driving CP0 strobes and the
// fetch redirect. Optional counters are built when EXC_STATS_EN is defined.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | WB may commit; strobes fire combinationally on wb_valid
//   REDIRECT | flush held, redirect_pc offered until fetch accepts it
module exc_commit_ctrl
   import mips_exc_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_BEV,
   parameter logic [4:0]  INT_EXCODE = EXC_INT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wb_valid,
   output logic        wb_ready,
   input  logic [31:0] wb_pc_in,
   input  logic        wb_bd_in,
   input  logic        wb_ex_in,
   input  logic [4:0]  wb_excode_in,
   input  logic [31:0] wb_badvaddr_in,
   input  logic        wb_eret,
   input  logic        wb_mtc0,
   input  logic [7:0]  int_req,
   input  logic        cp0_status_ie,
   input  logic        cp0_status_exl,
   input  logic [31:0] cp0_epc,
   output logic        wb_ex,
   output logic [4:0]  wb_excode,
   output logic        wb_bd,
   output logic [31:0] wb_pc,
   output logic [31:0] wb_badvaddr,
   output logic        eret_flush,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready
`ifdef EXC_STATS_EN
   ,
   output logic [31:0] exc_cnt,
   output logic [31:0] int_cnt
`endif
);

   localparam logic [0:0] IDLE     = ST_IDLE;
   localparam logic [0:0] REDIRECT = ST_REDIRECT;

   logic [0:0] state;
   logic       int_pend;
   logic       fire;
   logic       take_int;
   logic       take_exc;
   logic       take_eret;
   logic       mtc0_commit;

   exc_int_sampler u_int_sampler (
      .clk            (clk),
      .resetn         (resetn),
      .int_req        (int_req),
      .cp0_status_ie  (cp0_status_ie),
      .cp0_status_exl (cp0_status_exl),
      .mtc0_commit    (mtc0_commit),
      .int_pend       (int_pend)
   );

   assign wb_ready  = (state == IDLE);
   assign fire      = wb_valid & wb_ready;
   assign take_int  = fire & int_pend;
   assign take_exc  = fire & ~int_pend & wb_ex_in;
   assign take_eret = fire & ~int_pend & ~wb_ex_in & wb_eret;

   // An MTC0 only counts as committed when nothing preempts it.
   assign mtc0_commit = fire & ~int_pend & ~wb_ex_in & ~wb_eret & wb_mtc0;

   assign wb_ex       = take_int | take_exc;
   assign wb_excode   = take_int ? INT_EXCODE : (take_exc ? wb_excode_in : 5'd0);
   assign wb_bd       = wb_ex & wb_bd_in;
   assign wb_pc       = wb_ex ? wb_pc_in : 32'd0;
   assign wb_badvaddr = wb_ex ? wb_badvaddr_in : 32'd0;
   assign eret_flush  = take_eret;

   assign redirect_valid = (state == REDIRECT);
   assign flush          = redirect_valid | wb_ex | eret_flush;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         redirect_pc <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (wb_ex) begin
                  redirect_pc <= EXC_VECTOR;
                  state       <= REDIRECT;
               end else if (eret_flush) begin
                  redirect_pc <= cp0_epc;
                  state       <= REDIRECT;
               end
            end
            default: begin
               if (redirect_ready) begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

`ifdef EXC_STATS_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         exc_cnt <= 32'd0;
         int_cnt <= 32'd0;
      end else begin
         if (wb_ex && (wb_excode != INT_EXCODE)) begin
            exc_cnt <= exc_cnt + 32'd1;
         end
         if (take_int) begin
            int_cnt <= int_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: a vector table for single commits plus
// hand-written interrupt, ERET, MTC0-masking, priority and reset sequences.
module tb_exc_commit_ctrl;

   logic        clk;
   logic        resetn;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_pc_in;
   logic        wb_bd_in;
   logic        wb_ex_in;
   logic [4:0]  wb_excode_in;
   logic [31:0] wb_badvaddr_in;
   logic        wb_eret;
   logic        wb_mtc0;
   logic [7:0]  int_req;
   logic        cp0_status_ie;
   logic        cp0_status_exl;
   logic [31:0] cp0_epc;
   logic        wb_ex;
   logic [4:0]  wb_excode;
   logic        wb_bd;
   logic [31:0] wb_pc;
   logic [31:0] wb_badvaddr;
   logic        eret_flush;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;
`ifdef EXC_STATS_EN
   logic [31:0] exc_cnt;
   logic [31:0] int_cnt;
`endif

   exc_commit_ctrl dut (
      .clk            (clk),
      .resetn         (resetn),
      .wb_valid       (wb_valid),
      .wb_ready       (wb_ready),
      .wb_pc_in       (wb_pc_in),
      .wb_bd_in       (wb_bd_in),
      .wb_ex_in       (wb_ex_in),
      .wb_excode_in   (wb_excode_in),
      .wb_badvaddr_in (wb_badvaddr_in),
      .wb_eret        (wb_eret),
      .wb_mtc0        (wb_mtc0),
      .int_req        (int_req),
      .cp0_status_ie  (cp0_status_ie),
      .cp0_status_exl (cp0_status_exl),
      .cp0_epc        (cp0_epc),
      .wb_ex          (wb_ex),
      .wb_excode      (wb_excode),
      .wb_bd          (wb_bd),
      .wb_pc          (wb_pc),
      .wb_badvaddr    (wb_badvaddr),
      .eret_flush     (eret_flush),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ready (redirect_ready)
`ifdef EXC_STATS_EN
      ,
      .exc_cnt        (exc_cnt),
      .int_cnt        (int_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ex;
      logic [4:0]  excode;
      logic        bd;
      logic [31:0] pc;
      logic [31:0] badv;
      logic        eret;
      logic        flush;
      logic        ready;
      logic        rv;
      logic [31:0] rpc;
   } exp_t;

   typedef struct {
      logic        valid;
      logic        ex_in;
      logic [4:0]  excode;
      logic        eret;
      logic [31:0] pc;
      logic        bd;
      logic [31:0] badv;
      logic [31:0] epc;
      logic        exp_ex;
      logic [4:0]  exp_excode;
      logic        exp_bd;
      logic [31:0] exp_pc;
      logic [31:0] exp_badv;
      logic        exp_eret;
      logic [31:0] exp_rpc;
   } vec_t;

   localparam int NV = 8;
   localparam logic [31:0] VEC = 32'hbfc00380;

   vec_t vecs [NV];
   exp_t exp_q [$];
   int   total = 0;
   int   bad   = 0;

   function automatic exp_t mk(logic ex, logic [4:0] excode, logic bd, logic [31:0] pc,
                               logic [31:0] badv, logic eret, logic fl, logic rdy,
                               logic rv, logic [31:0] rpc);
      exp_t e;
      e.ex = ex; e.excode = excode; e.bd = bd; e.pc = pc; e.badv = badv;
      e.eret = eret; e.flush = fl; e.ready = rdy; e.rv = rv; e.rpc = rpc;
      return e;
   endfunction

   function automatic exp_t idle_e();
      return mk(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
   endfunction

   function automatic exp_t normal_e();
      return mk(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
   endfunction

   function automatic exp_t redir_e(logic [31:0] rpc);
      return mk(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, rpc);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Push the expectation for the current cycle, then pop and compare at the negedge.
   task automatic step(input string name, input exp_t e);
      exp_t got;
      exp_q.push_back(e);
      @(negedge clk);
      got = exp_q.pop_front();
      chk({name, ".wb_ex"},          {31'd0, wb_ex},          {31'd0, got.ex});
      chk({name, ".wb_excode"},      {27'd0, wb_excode},      {27'd0, got.excode});
      chk({name, ".wb_bd"},          {31'd0, wb_bd},          {31'd0, got.bd});
      chk({name, ".wb_pc"},          wb_pc,                   got.pc);
      chk({name, ".wb_badvaddr"},    wb_badvaddr,             got.badv);
      chk({name, ".eret_flush"},     {31'd0, eret_flush},     {31'd0, got.eret});
      chk({name, ".flush"},          {31'd0, flush},          {31'd0, got.flush});
      chk({name, ".wb_ready"},       {31'd0, wb_ready},       {31'd0, got.ready});
      chk({name, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, got.rv});
      if (got.rv) chk({name, ".redirect_pc"}, redirect_pc, got.rpc);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_wb();
      wb_valid = 1'b0; wb_pc_in = 32'd0; wb_bd_in = 1'b0; wb_ex_in = 1'b0;
      wb_excode_in = 5'd0; wb_badvaddr_in = 32'd0; wb_eret = 1'b0; wb_mtc0 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 1'b0, 5'd0,  1'b0, 32'h00400000, 1'b1, 32'h0000dead, 32'h0,
                  1'b0, 5'd0,  1'b0, 32'h0,          32'h0,          1'b0, 32'h0};
      vecs[1] = '{1'b1, 1'b1, 5'd4,  1'b0, 32'h00002004, 1'b1, 32'h00001001, 32'h0,
                  1'b1, 5'd4,  1'b1, 32'h00002004,  32'h00001001,   1'b0, VEC};
      vecs[2] = '{1'b1, 1'b0, 5'd0,  1'b1, 32'h00003000, 1'b0, 32'h0,        32'hbfc00040,
                  1'b0, 5'd0,  1'b0, 32'h0,          32'h0,          1'b1, 32'hbfc00040};
      vecs[3] = '{1'b1, 1'b1, 5'd12, 1'b1, 32'h00000400, 1'b0, 32'h00000077, 32'h11111111,
                  1'b1, 5'd12, 1'b0, 32'h00000400,  32'h00000077,   1'b0, VEC};
      vecs[4] = '{1'b0, 1'b1, 5'd5,  1'b1, 32'h00000500, 1'b1, 32'h00000099, 32'h22222222,
                  1'b0, 5'd0,  1'b0, 32'h0,          32'h0,          1'b0, 32'h0};
      vecs[5] = '{1'b1, 1'b1, 5'd9,  1'b0, 32'h80001000, 1'b0, 32'h0,        32'h00001234,
                  1'b1, 5'd9,  1'b0, 32'h80001000,  32'h0,          1'b0, VEC};
      vecs[6] = '{1'b1, 1'b0, 5'd0,  1'b1, 32'h00000abc, 1'b1, 32'h00000055, 32'h80000180,
                  1'b0, 5'd0,  1'b0, 32'h0,          32'h0,          1'b1, 32'h80000180};
      vecs[7] = '{1'b1, 1'b1, 5'd10, 1'b0, 32'hfffffffc, 1'b1, 32'hffffffff, 32'h0,
                  1'b1, 5'd10, 1'b1, 32'hfffffffc,  32'hffffffff,   1'b0, VEC};

      resetn = 1'b0; redirect_ready = 1'b0; int_req = 8'h00;
      cp0_status_ie = 1'b0; cp0_status_exl = 1'b0; cp0_epc = 32'd0;
      clear_wb();
      #12;
      chk("reset.redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk("reset.flush",          {31'd0, flush},          32'd0);
      chk("reset.redirect_pc",    redirect_pc,             32'd0);
      chk("reset.wb_ready",       {31'd0, wb_ready},       32'd1);
      @(posedge clk); #1;
      resetn = 1'b1;
      step("post_reset", idle_e());

      for (int i = 0; i < NV; i++) begin
         clear_wb();
         wb_valid = vecs[i].valid; wb_ex_in = vecs[i].ex_in; wb_excode_in = vecs[i].excode;
         wb_eret = vecs[i].eret; wb_pc_in = vecs[i].pc; wb_bd_in = vecs[i].bd;
         wb_badvaddr_in = vecs[i].badv; cp0_epc = vecs[i].epc;
         step($sformatf("vec%0d", i),
              mk(vecs[i].exp_ex, vecs[i].exp_excode, vecs[i].exp_bd, vecs[i].exp_pc,
                 vecs[i].exp_badv, vecs[i].exp_eret, vecs[i].exp_ex | vecs[i].exp_eret,
                 1'b1, 1'b0, 32'd0));
         if (vecs[i].exp_ex || vecs[i].exp_eret) begin
            wb_valid = 1'b0;
            cp0_epc  = 32'h5a5a5a5a;
            step($sformatf("vec%0d_redir", i), redir_e(vecs[i].exp_rpc));
            redirect_ready = 1'b1;
            step($sformatf("vec%0d_accept", i), redir_e(vecs[i].exp_rpc));
            redirect_ready = 1'b0;
         end
      end

      // Interrupt: one cycle of sampling latency, then strobe at the WB PC.
      clear_wb();
      cp0_status_ie = 1'b1; cp0_status_exl = 1'b0; int_req = 8'h80;
      wb_valid = 1'b1; wb_pc_in = 32'hbfc00100;
      step("int_latency", normal_e());
      step("int_take", mk(1'b1, 5'd0, 1'b0, 32'hbfc00100, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0));
      clear_wb();
      step("int_redir0", redir_e(VEC));
      step("int_redir1", redir_e(VEC));
      cp0_status_exl = 1'b1; int_req = 8'h00; redirect_ready = 1'b1;
      step("int_accept", redir_e(VEC));
      redirect_ready = 1'b0;
      step("int_back_idle", idle_e());

      // ERET with EXL=0, fetch stalls 3 cycles, a new WB op arrives during REDIRECT.
      cp0_status_ie = 1'b0; cp0_status_exl = 1'b0;
      wb_valid = 1'b1; wb_eret = 1'b1; wb_pc_in = 32'h00000100; cp0_epc = 32'hbfc00040;
      step("eret_fire", mk(1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0));
      wb_eret = 1'b0; wb_ex_in = 1'b1; wb_excode_in = 5'd8; cp0_epc = 32'h0;
      for (int k = 0; k < 3; k++) step($sformatf("eret_stall%0d", k), redir_e(32'hbfc00040));
      redirect_ready = 1'b1;
      step("eret_accept", redir_e(32'hbfc00040));
      redirect_ready = 1'b0;
      clear_wb();
      step("eret_back_idle", idle_e());

      // MTC0 masks interrupt sampling for the following cycle.
      cp0_status_ie = 1'b1; cp0_status_exl = 1'b0; int_req = 8'h00;
      wb_valid = 1'b1; wb_mtc0 = 1'b1; wb_pc_in = 32'h00000600;
      step("mtc0_commit", normal_e());
      wb_mtc0 = 1'b0; int_req = 8'h01; wb_pc_in = 32'h00000604;
      step("mtc0_hold1", normal_e());
      wb_pc_in = 32'h00000608;
      step("mtc0_hold2", normal_e());
      wb_pc_in = 32'h0000060c;
      step("mtc0_int", mk(1'b1, 5'd0, 1'b0, 32'h0000060c, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0));
      clear_wb();
      cp0_status_exl = 1'b1; int_req = 8'h00; redirect_ready = 1'b1;
      step("mtc0_accept", redir_e(VEC));
      redirect_ready = 1'b0;
      step("mtc0_back_idle", idle_e());

      // Interrupt beats a carried exception; only one strobe.
      cp0_status_exl = 1'b0; cp0_status_ie = 1'b1; int_req = 8'h80;
      step("prio_sample", idle_e());
      wb_valid = 1'b1; wb_ex_in = 1'b1; wb_excode_in = 5'd10;
      wb_pc_in = 32'h00000700; wb_bd_in = 1'b1; wb_badvaddr_in = 32'h00000abc;
      step("prio_fire", mk(1'b1, 5'd0, 1'b1, 32'h00000700, 32'h00000abc, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0));
      clear_wb();
      cp0_status_exl = 1'b1; int_req = 8'h00;
      step("prio_single", redir_e(VEC));
      redirect_ready = 1'b1;
      step("prio_accept", redir_e(VEC));
      redirect_ready = 1'b0;
      step("prio_back_idle", idle_e());

      // Asynchronous reset in the middle of REDIRECT.
      cp0_status_ie = 1'b0; cp0_status_exl = 1'b0;
      wb_valid = 1'b1; wb_ex_in = 1'b1; wb_excode_in = 5'd12; wb_pc_in = 32'h00000800;
      step("rst_fire", mk(1'b1, 5'd12, 1'b0, 32'h00000800, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0));
      clear_wb();
      step("rst_redir", redir_e(VEC));
      resetn = 1'b0;
      #1;
      chk("rst_async.redirect_valid", {31'd0, redirect_valid}, 32'd0);
      chk("rst_async.flush",          {31'd0, flush},          32'd0);
      chk("rst_async.redirect_pc",    redirect_pc,             32'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      step("rst_release", idle_e());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
